// File: rtl/bus_rr_bcast_pkg.sv
// Shared types and helpers for the broadcast-capable bus controller.
// Packet destination decode lives here so every user agrees on it.
package bus_rr_bcast_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    DELIVER = 2'd2
  } bus_state_e;

  localparam logic [7:0] BCAST_DEF = 8'hFF;
  localparam int         PKT_MAX   = 64;

  // Destination ID is the top byte of a packet of width w.
  function automatic logic [7:0] dest_of(
    input logic [PKT_MAX-1:0] pkt,
    input int                 w
  );
    return 8'(pkt >> (w - 8));
  endfunction

endpackage

// File: rtl/bus_rr_bcast_if.sv
// Device-side FIFO bundle of the shared bus controller.
// The master is the controller; the slave side is the device FIFO array.
interface bus_rr_bcast_if #(
  parameter int DRVRS   = 4,
  parameter int PCKG_SZ = 16
);

  logic [DRVRS-1:0]              pndng;
  logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]              pop;
  logic [DRVRS-1:0]              push;
  logic [DRVRS-1:0][PCKG_SZ-1:0] D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );

endinterface

// File: rtl/bus_rr_bcast_arb.sv
// Combinational arbiter: round-robin from ptr+1, or fixed lowest-index.
// Returns a binary grant index plus a valid flag.
module bus_rr_bcast_arb #(
  parameter int N       = 4,
  parameter int RR_MODE = 1,
  localparam int IW     = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  int j;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (RR_MODE != 0) ? int'(ptr) + 1 + k : k;
      if (j >= N) j = j - N;
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_rr_bcast.sv
// Shared-bus controller: one packet per 3-cycle transfer from a
// granted device to its destination, all-but-source, or the drop bin.
module bus_rr_bcast
  import bus_rr_bcast_pkg::*;
#(
  parameter int         DRVRS     = 4,
  parameter int         PCKG_SZ   = 16,
  parameter logic [7:0] BROADCAST = BCAST_DEF,
  parameter int         RR_MODE   = 1,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  bus_rr_bcast_if.master   bus,
  output logic             busy,
  output logic             drop,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int IW = $clog2(DRVRS);

  bus_state_e state_q;
  bus_state_e state_d;

  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      g_q;
  logic [IW-1:0]      src_q;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic [PCKG_SZ-1:0] pkt_q;
  logic [PCKG_SZ-1:0] hold_q;

  logic [7:0] dest;
  logic       is_bc;
  logic       in_rng;
  logic       is_self;
  logic       is_uni;

  bus_rr_bcast_arb #(
    .N       (DRVRS),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req     (bus.pndng),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_vld) state_d = POP;
      POP:     state_d = DELIVER;
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer starts at the last device so device 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= IW'(DRVRS - 1);
      g_q      <= '0;
      src_q    <= '0;
      pkt_q    <= '0;
      hold_q   <= '0;
      drop_cnt <= '0;
    end else begin
      if (state_q == IDLE && gnt_vld) begin
        g_q <= gnt_idx;
        if (RR_MODE != 0) ptr_q <= gnt_idx;
      end
      if (state_q == POP) begin
        pkt_q <= bus.D_pop[g_q];
        src_q <= g_q;
      end
      if (state_q == DELIVER) begin
        hold_q <= pkt_q;
        if (drop && !(&drop_cnt))
          drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign dest    = dest_of(PKT_MAX'(pkt_q), PCKG_SZ);
  assign is_bc   = (dest == BROADCAST);
  assign in_rng  = (dest < 8'(DRVRS));
  assign is_self = (dest == 8'(src_q));
  assign is_uni  = !is_bc && in_rng && !is_self;

  always_comb begin
    bus.pop    = '0;
    bus.push   = '0;
    bus.D_push = {DRVRS{hold_q}};
    drop       = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      POP: bus.pop[g_q] = 1'b1;
      DELIVER: begin
        bus.D_push = {DRVRS{pkt_q}};
        unique case (1'b1)
          is_bc:   bus.push = ~(DRVRS'(1) << src_q);
          is_uni:  bus.push = DRVRS'(1) << dest;
          default: drop = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_rr_bcast.sv
// Bench for bus_rr_bcast: 4-dev RR, 4-dev fixed and 8-dev/32-bit
// instances; device FIFO models feed a scoreboard of expected deliveries.
module tb_bus_rr_bcast;
  import bus_rr_bcast_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_rr_bcast_if #(.DRVRS(4), .PCKG_SZ(16)) b0 ();
  bus_rr_bcast_if #(.DRVRS(4), .PCKG_SZ(16)) b1 ();
  bus_rr_bcast_if #(.DRVRS(8), .PCKG_SZ(32)) b2 ();

  logic        busy0, drop0, busy1, drop1, busy2, drop2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  bus_rr_bcast #(
    .DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF),
    .RR_MODE(1), .CNT_W(16)
  ) u0 (
    .clk(clk), .reset(reset), .bus(b0),
    .busy(busy0), .drop(drop0), .drop_cnt(cnt0)
  );

  bus_rr_bcast #(
    .DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF),
    .RR_MODE(0), .CNT_W(16)
  ) u1 (
    .clk(clk), .reset(reset), .bus(b1),
    .busy(busy1), .drop(drop1), .drop_cnt(cnt1)
  );

  bus_rr_bcast #(
    .DRVRS(8), .PCKG_SZ(32), .BROADCAST(8'hFF),
    .RR_MODE(1), .CNT_W(2)
  ) u2 (
    .clk(clk), .reset(reset), .bus(b2),
    .busy(busy2), .drop(drop2), .drop_cnt(cnt2)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          src;
    logic [3:0]  push;
    logic [15:0] data;
    logic        drop;
  } exp_t;

  typedef struct {
    int          src;
    logic [15:0] pkt;
    logic [3:0]  push;
    logic        drop;
  } vec_t;

  exp_t    sbq[$];
  longint  gapq[$];
  longint  last_pop = 0;
  int      exp_drops = 0;

  // Device FIFO models for u0
  logic [15:0] mem[4][16];
  int          wr[4] = '{0, 0, 0, 0};
  int          rd[4] = '{0, 0, 0, 0};
  logic [3:0]  popm = '0;

  always @(negedge clk) popm = b0.pop;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (popm[i]) rd[i]++;
      b0.pndng[i] = (rd[i] != wr[i]);
      b0.D_pop[i] = mem[i][rd[i] % 16];
    end
  end

  task automatic enq(int d, logic [15:0] p,
                     logic [3:0] m, logic dr);
    exp_t e;
    mem[d][wr[d] % 16] = p;
    wr[d]++;
    e.src  = d;
    e.push = m;
    e.data = p;
    e.drop = dr;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (b0.pop != 0) begin
        if (sbq.size() == 0) chk("unexp_pop", 64'(b0.pop), 0);
        else begin
          chk("pop_src", 64'(b0.pop), 64'(4'b0001 << sbq[0].src));
          gapq.push_back(longint'($time) - last_pop);
          last_pop = longint'($time);
        end
      end
      if (b0.push != 0 || drop0) begin
        if (sbq.size() == 0)
          chk("unexp_deliv", 64'({b0.push, drop0}), 0);
        else begin
          e = sbq.pop_front();
          chk("push", 64'(b0.push), 64'(e.push));
          chk("drop", 64'(drop0), 64'(e.drop));
          for (int i = 0; i < 4; i++)
            chk("d_push", 64'(b0.D_push[i]), 64'(e.data));
          if (e.drop) exp_drops++;
        end
      end
    end
  end

  task automatic drain(string nm);
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk({nm, "_timeout"}, 64'(sbq.size()), 0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic send8(input logic [31:0] p,
                       output logic [7:0] psh,
                       output logic [31:0] dp,
                       output logic dr);
    int n = 0;
    b2.D_pop[7] = p;
    b2.pndng    = 8'h80;
    do begin
      @(negedge clk);
      n++;
    end while (b2.pop == 0 && n < 20);
    chk("u2_pop", 64'(b2.pop), 64'h80);
    b2.pndng = '0;
    @(negedge clk);
    psh = b2.push;
    dp  = b2.D_push[0];
    dr  = drop2;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  vec_t        vt[6];
  logic [7:0]  psh;
  logic [31:0] dp;
  logic        dr;
  longint      t, lt;
  int          n;

  initial begin
    vt[0] = '{0, 16'h02AB, 4'b0100, 1'b0};
    vt[1] = '{2, 16'hFF55, 4'b1011, 1'b0};
    vt[2] = '{1, 16'h0711, 4'b0000, 1'b1};
    vt[3] = '{1, 16'h0111, 4'b0000, 1'b1};
    vt[4] = '{3, 16'h0000, 4'b0001, 1'b0};
    vt[5] = '{0, 16'hFF00, 4'b1110, 1'b0};

    b1.pndng = 4'hF;
    b1.D_pop = {4{16'h0100}};
    b2.pndng = '0;
    b2.D_pop = '0;

    repeat (3) @(negedge clk);
    chk("rst_pop", 64'(b0.pop), 0);
    chk("rst_push", 64'(b0.push), 0);
    chk("rst_busy", 64'(busy0), 0);
    chk("rst_drop", 64'(drop0), 0);
    chk("rst_cnt", 64'(cnt0), 0);
    chk("rst_dpush", 64'(b0.D_push[1]), 0);
    chk("rst_cnt2", 64'(cnt2), 0);
    reset = 1'b0;

    // fixed priority: device 0 always wins
    lt = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (b1.pop == 0 && n < 10);
      t = longint'($time);
      chk("fixed_gnt", 64'(b1.pop), 64'h1);
      if (k > 0) chk("fixed_gap", 64'(t - lt), 30);
      lt = t;
    end
    drain("idle");

    // latency: pndng seen at edge n, pop at n+1, push at n+2
    enq(0, 16'h02AB, 4'b0100, 1'b0);
    @(negedge clk);
    chk("lat_pre", 64'(b0.pop), 0);
    @(negedge clk);
    chk("lat_pop", 64'(b0.pop), 64'h1);
    @(negedge clk);
    chk("lat_push", 64'(b0.push), 64'h4);
    chk("lat_data", 64'(b0.D_push[2]), 64'h02AB);
    drain("lat");

    for (int i = 0; i < 6; i++) begin
      enq(vt[i].src, vt[i].pkt, vt[i].push, vt[i].drop);
      drain("vec");
      chk("vec_cnt", 64'(cnt0), 64'(exp_drops));
    end
    chk("vec_dhold", 64'(b0.D_push[0]), 64'hFF00);

    // round robin order 0,1,2,3,0 from a fresh pointer
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_drops = 0;
    gapq.delete();
    enq(0, 16'h0100, 4'b0010, 1'b0);
    enq(1, 16'h0200, 4'b0100, 1'b0);
    enq(2, 16'h0300, 4'b1000, 1'b0);
    enq(3, 16'h0000, 4'b0001, 1'b0);
    enq(0, 16'h0101, 4'b0010, 1'b0);
    drain("rr");
    chk("rr_npop", 64'(gapq.size()), 5);
    for (int i = 1; i < 5; i++)
      if (i < gapq.size())
        chk("rr_gap", 64'(gapq[i]), 30);

    // reset during the push cycle
    enq(1, 16'h0312, 4'b1000, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b0.push == 0 && n < 20);
    chk("mid_push_seen", 64'(b0.push), 64'h8);
    #2 reset = 1'b1;
    #1;
    chk("mid_push", 64'(b0.push), 0);
    chk("mid_pop", 64'(b0.pop), 0);
    chk("mid_busy", 64'(busy0), 0);
    chk("mid_dpush", 64'(b0.D_push[3]), 0);
    @(negedge clk);
    reset = 1'b0;
    exp_drops = 0;
    enq(0, 16'h0211, 4'b0100, 1'b0);
    enq(2, 16'h0011, 4'b0001, 1'b0);
    drain("post_rst");

    // 8 devices, 32-bit packets, 2-bit drop counter
    send8(32'h0500_1234, psh, dp, dr);
    chk("w_push", 64'(psh), 64'h20);
    chk("w_data", 64'(dp), 64'h0500_1234);
    chk("w_drop", 64'(dr), 0);
    for (int k = 0; k < 4; k++) begin
      send8(32'h0900_00AA, psh, dp, dr);
      chk("sat_push", 64'(psh), 0);
      chk("sat_drop", 64'(dr), 1);
      chk("sat_cnt", 64'(cnt2), 64'((k < 2) ? k + 1 : 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
